// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit with a small {word, address} queue.
//
// A fetch-address register FA walks sequentially through instruction memory
// one 32-bit word at a time. Fetched words land in a queue whose head is
// presented to the control unit as Inst/PC. The control unit consumes the
// head with PC_SEL (hold, advance, branch, register jump). A redirect flushes
// the queue and retargets FA.
//
// Ports:
//   CLK        in   clock, all state on posedge
//   Reset      in   synchronous active-low reset
//   PC_SEL     in   [1:0] 00 hold, 01 advance, 10 branch, 11 register jump
//   PC_MUX     in   branch source for PC_SEL=10: 1 = PC + (K<<2), 0 = A
//   K          in   [63:0] branch word offset
//   A          in   [63:0] absolute target from the register file
//   mem_req    out  instruction memory read request
//   mem_addr   out  [63:0] byte address of the request
//   mem_ack    in   read complete, mem_rdata valid in the same cycle
//   mem_rdata  in   [31:0] fetched instruction word
//   Inst       out  [31:0] head instruction
//   Inst_valid out  head instruction is valid
//   PC         out  [63:0] byte address of Inst
//
// Build option:
//   INST_FETCH_PREFETCH_EN  2-entry queue with fetch-ahead; otherwise 1 entry.
//
// state | meaning
// IDLE  | no request outstanding; waiting for a free queue slot
// REQ   | mem_req held at mem_addr until mem_ack

module inst_fetch (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [1:0]  PC_SEL,
  input  logic        PC_MUX,
  input  logic [63:0] K,
  input  logic [63:0] A,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] Inst,
  output logic        Inst_valid,
  output logic [63:0] PC
);

`ifdef INST_FETCH_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [63:0] fa_q, fa_d;
  logic        discard_q, discard_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] word0_q, word0_d, word1_q, word1_d;
  logic [63:0] addr0_q, addr0_d, addr1_q, addr1_d;

  logic        consume, redirect, pop, ack, accept;
  logic [63:0] target;
  logic [1:0]  base;

  always_comb begin
    consume  = (count_q != 2'd0) && (PC_SEL != 2'b00);
    redirect = consume && PC_SEL[1];
    pop      = consume && (PC_SEL == 2'b01);
    target   = (PC_SEL == 2'b10 && PC_MUX) ? addr0_q + (K << 2) : A;
    ack      = (state_q == REQ) && mem_ack;
    // A returning word is dropped if it belongs to a pre-redirect request or
    // if a redirect lands on the same edge.
    accept   = ack && !discard_q && !redirect;

    word0_d = word0_q;
    addr0_d = addr0_q;
    word1_d = word1_q;
    addr1_d = addr1_q;
    if (pop) begin
      word0_d = word1_q;
      addr0_d = addr1_q;
    end
    // occupancy after the pop, i.e. the slot a push lands in
    base = count_q - {1'b0, pop};
    if (accept) begin
      if (base == 2'd0) begin
        word0_d = mem_rdata;
        addr0_d = fa_q;
      end else begin
        word1_d = mem_rdata;
        addr1_d = fa_q;
      end
    end
    count_d = redirect ? 2'd0 : base + {1'b0, accept};
    fa_d    = redirect ? target : (accept ? fa_q + 64'd4 : fa_q);

    // A redirect while a request is in flight cannot abort the handshake,
    // so the response is marked for discard instead.
    discard_d = discard_q;
    if (ack) begin
      discard_d = 1'b0;
    end else if (redirect && state_q == REQ) begin
      discard_d = 1'b1;
    end

    // On ack the next request chains straight from REQ when a slot is still
    // free, which is what lets the 2-entry build sustain one word per cycle.
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    if (state_q == IDLE || ack) begin
      if (count_d < DEPTH) begin
        state_d    = REQ;
        mem_addr_d = fa_d;
      end else begin
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q    <= IDLE;
      fa_q       <= 64'd0;
      discard_q  <= 1'b0;
      mem_addr_q <= 64'd0;
      count_q    <= 2'd0;
      word0_q    <= 32'd0;
      addr0_q    <= 64'd0;
      word1_q    <= 32'd0;
      addr1_q    <= 64'd0;
    end else begin
      state_q    <= state_d;
      fa_q       <= fa_d;
      discard_q  <= discard_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      word0_q    <= word0_d;
      addr0_q    <= addr0_d;
      word1_q    <= word1_d;
      addr1_q    <= addr1_d;
    end
  end

  assign mem_req    = (state_q == REQ);
  assign mem_addr   = mem_addr_q;
  assign Inst       = word0_q;
  assign PC         = addr0_q;
  assign Inst_valid = (count_q != 2'd0);

endmodule
